// File: rtl/ks_digit_recomposer_if.sv
// Digit-in / coefficient-out stream bundle for the keyswitch digit recomposer.
interface ks_digit_recomposer_if #(
    parameter int unsigned DIGIT_W   = 3,
    parameter int unsigned MOD_KSK_W = 21
);
    logic [DIGIT_W-1:0]   in_digit;
    logic                 in_last;
    logic                 in_vld;
    logic                 in_rdy;
    logic [MOD_KSK_W-1:0] out_coef;
    logic                 out_vld;
    logic                 out_rdy;
    logic                 err_level;
    logic                 err_digit;

    modport master (
        output in_digit, in_last, in_vld, out_rdy,
        input  in_rdy, out_coef, out_vld, err_level, err_digit
    );

    modport slave (
        input  in_digit, in_last, in_vld, out_rdy,
        output in_rdy, out_coef, out_vld, err_level, err_digit
    );
endinterface

// File: rtl/ks_digit_recomposer.sv
// Rebuilds a coefficient mod 2^MOD_KSK_W from KS_L balanced signed digits, MS level first.
// Optional digit range check enabled by defining KS_RECOMP_DIGIT_CHECK_EN.
module ks_digit_recomposer #(
    parameter int unsigned KS_L      = 8,
    parameter int unsigned KS_B_W    = 2,
    parameter int unsigned MOD_KSK_W = 21,
    parameter int unsigned DIGIT_W   = KS_B_W + 1
) (
    input  logic                   clk,
    input  logic                   s_rst,
    ks_digit_recomposer_if.slave   bus
);
    localparam int unsigned LVL_W    = (KS_L > 1) ? $clog2(KS_L) : 1;
    localparam int unsigned ALIGN_SH = MOD_KSK_W - KS_L * KS_B_W;
    localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(KS_L - 1);

    logic [LVL_W-1:0]     lvl_q, lvl_d;
    logic [MOD_KSK_W-1:0] acc_q, acc_d;
    logic [MOD_KSK_W-1:0] out_coef_q, out_coef_d;
    logic                 out_vld_q, out_vld_d;
    logic                 err_level_q, err_level_d;

    logic                 in_rdy_c;
    logic                 accept_c;
    logic                 is_last_c;
    logic [MOD_KSK_W-1:0] acc_base_c;
    logic [MOD_KSK_W-1:0] digit_ext_c;
    logic [MOD_KSK_W-1:0] acc_next_c;

    // Only a stalled pending coefficient blocks new digits.
    assign in_rdy_c  = !(out_vld_q && !bus.out_rdy);
    assign accept_c  = bus.in_vld && in_rdy_c;
    assign is_last_c = (lvl_q == LVL_LAST);

    always_comb begin
        lvl_d       = lvl_q;
        acc_d       = acc_q;
        out_coef_d  = out_coef_q;
        out_vld_d   = out_vld_q;
        err_level_d = 1'b0;

        acc_base_c  = (lvl_q == '0) ? '0 : acc_q;
        digit_ext_c = MOD_KSK_W'($signed(bus.in_digit));
        acc_next_c  = (acc_base_c << KS_B_W) + digit_ext_c;

        if (out_vld_q && bus.out_rdy) begin
            out_vld_d = 1'b0;
        end

        if (accept_c) begin
            acc_d       = acc_next_c;
            lvl_d       = is_last_c ? '0 : lvl_q + LVL_W'(1);
            err_level_d = (bus.in_last != is_last_c);
            // Framing comes from the level counter; in_last is only checked.
            if (is_last_c) begin
                out_coef_d = acc_next_c << ALIGN_SH;
                out_vld_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (s_rst) begin
            lvl_q       <= '0;
            acc_q       <= '0;
            out_coef_q  <= '0;
            out_vld_q   <= 1'b0;
            err_level_q <= 1'b0;
        end else begin
            lvl_q       <= lvl_d;
            acc_q       <= acc_d;
            out_coef_q  <= out_coef_d;
            out_vld_q   <= out_vld_d;
            err_level_q <= err_level_d;
        end
    end

    assign bus.in_rdy    = in_rdy_c;
    assign bus.out_coef  = out_coef_q;
    assign bus.out_vld   = out_vld_q;
    assign bus.err_level = err_level_q;

`ifdef KS_RECOMP_DIGIT_CHECK_EN
    localparam int DIG_MAX = 2 ** (KS_B_W - 1);

    logic err_digit_q, err_digit_d;
    logic digit_oob_c;

    // Balanced range is symmetric: [-2^(B-1), +2^(B-1)].
    assign digit_oob_c = (int'($signed(bus.in_digit)) > DIG_MAX) ||
                         (int'($signed(bus.in_digit)) < -DIG_MAX);
    assign err_digit_d = accept_c && digit_oob_c;

    always_ff @(posedge clk) begin
        if (s_rst) begin
            err_digit_q <= 1'b0;
        end else begin
            err_digit_q <= err_digit_d;
        end
    end

    assign bus.err_digit = err_digit_q;
`else
    assign bus.err_digit = 1'b0;
`endif

endmodule

// File: doc/ks_digit_recomposer.md
# ks_digit_recomposer

Streaming recomposer for keyswitch balanced signed-digit decompositions: accepts KS_L digits per coefficient, most-significant level first, and rebuilds the closest-representable coefficient modulo 2^MOD_KSK_W. It is the inverse of the KS decomposer and sits beside it in the keyswitch datapath. Its uses are on-chip self-check of the decomposer (decompose → recompose → compare) and rebuilding KSK-domain values from digit streams in debug/readback paths.

## Interface
Parameters:
- KS_L, 8, number of decomposition levels (digits per coefficient).
- KS_B_W, 2, decomposition base width in bits.
- MOD_KSK_W, 21, coefficient width; results are modulo 2^MOD_KSK_W; requires KS_L*KS_B_W ≤ MOD_KSK_W.
- DIGIT_W, KS_B_W+1, signed digit width (two's complement).

Ports:
- clk  in  1  clock.
- s_rst  in  1  reset; synchronous, active-high.
- in_digit  in  DIGIT_W  signed digit.
- in_last  in  1  marks the level-KS_L digit; checked only, never used to close a coefficient.
- in_vld  in  1  digit valid.
- in_rdy  out  1  digit ready.
- out_coef  out  MOD_KSK_W  recomposed coefficient.
- out_vld  out  1  coefficient valid.
- out_rdy  in  1  coefficient ready.
- err_level  out  1  one-cycle pulse: in_last mismatch.
- err_digit  out  1  one-cycle pulse: digit outside balanced range; only driven when KS_RECOMP_DIGIT_CHECK_EN is defined.

## Operation
- Digit accepted when in_vld && in_rdy. in_rdy = !(out_vld && !out_rdy). This is combinational from out_vld/out_rdy and is independent of in_vld.
- Level counter lvl, 0..KS_L-1, increments on each accepted digit and wraps to 0 after KS_L-1.
- Accumulator acc, MOD_KSK_W bits, updated by Horner rule on accept: acc_next = ((lvl==0 ? 0 : acc) << KS_B_W) + sign_ext(in_digit), mod 2^MOD_KSK_W.
- Closing digit is the digit accepted at lvl==KS_L-1. On it:
  - out_coef <= acc_next << (MOD_KSK_W − KS_L*KS_B_W), truncated to MOD_KSK_W bits.
  - out_vld <= 1.
- The final shift aligns level 1 to weight 2^(MOD_KSK_W−KS_B_W). Low bits of the result are always zero.
- out_vld clears on out_rdy unless a new closing digit is accepted in the same cycle; in that case out_coef and out_vld are reloaded.
- out_coef stays stable while out_vld && !out_rdy.
- err_level pulses on any accepted digit where in_last != (lvl==KS_L-1). Accumulation and emission proceed unchanged, so the counter alone decides framing.
- All arithmetic is wrap-around modulo 2^MOD_KSK_W. There is no saturation.

## Timing
- Reset values: in_rdy=1, out_vld=0, out_coef=0, err_level=0, err_digit=0, lvl=0, acc=0.
- Throughput: one digit per cycle; one coefficient every KS_L cycles when out_rdy is held at 1.
- Latency: out_vld asserts the cycle after the closing digit is accepted.
- Back-to-back: a closing digit accepted while out_vld && out_rdy reloads the output with no bubble.
- Backpressure: with out_vld=1 and out_rdy=0, in_rdy=0. No digit is consumed and lvl/acc hold.
- Error pulses (err_level, err_digit) are registered and appear the cycle after the offending accept.
- s_rst mid-coefficient: partial acc discarded, lvl=0, pending out_coef dropped (out_vld=0). The next accepted digit is level 1.

## Configuration
- KS_RECOMP_DIGIT_CHECK_EN defined:
  - Legal digit range is the balanced range [−2^(KS_B_W−1), +2^(KS_B_W−1)], i.e. [−2, 2] at default parameters.
  - err_digit pulses for any accepted digit outside that range (−4, −3, +3 at default).
  - The digit is still accumulated.
- Not defined: err_digit tied to 0 and no range logic is instantiated.

## Test plan
- Eight digits of +1, in_last on the 8th, out_rdy=1 → out_coef=0x0AAAA0 one cycle after the 8th accept; err_level=0.
- Level-1 digit −1, remaining seven 0 → out_coef=0x180000. Level-1 digit +2, remaining seven 0 → out_coef=0x100000.
- Three back-to-back all-zero coefficients with out_rdy=1 → three out_vld pulses spaced 8 cycles apart, each with out_coef=0, and in_rdy never drops.
- Hold out_rdy=0 after the first coefficient → in_rdy=0 and out_coef stable. Release out_rdy → second coefficient continues from level 1 and is correct.
- in_last asserted on the 5th digit → err_level pulses once; the coefficient is still emitted after the 8th digit.
- With the macro, digit +3 at level 1 → err_digit pulses and out_coef=0x180000 (3·2^19 mod 2^21). Without the macro, err_digit stays 0. Also assert s_rst after 4 digits → out_vld stays 0 and the next 8 digits recompose cleanly.
